io_stall_controller: RTL and testbench
======================================

# io_stall_controller

Sequencer between the combinational control decoder and the PC, register file, data memory and board I/O. It turns the decoder's `halt`, `input_flag` and `output_flag` strobes into multi-cycle behaviour:
- stalls the PC on an input instruction until the operator confirms with a debounced button press/release,
- latches output values for the display,
- freezes the core permanently on HALT.

It also gates `regWrite`/`memWrite` so that no architectural write happens during a stall.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of switch input and display value
- `DEBOUNCE_CYCLES`, 4, consecutive stable synchronized samples required for press or release (≥1, counter width `$clog2(DEBOUNCE_CYCLES+1)`)

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `halt`  in  1  decoder HALT strobe for current instruction
- `input_flag`  in  1  decoder input-instruction strobe
- `output_flag`  in  1  decoder output-instruction strobe
- `reg_write_in`  in  1  decoder `regWrite`
- `mem_write_in`  in  1  decoder `memWrite`
- `enter_btn`  in  1  raw asynchronous confirm button
- `switch_data`  in  DATA_WIDTH  board switches
- `out_data`  in  DATA_WIDTH  register-file read value for output instruction
- `pc_enable`  out  1  PC and instruction retire enable
- `reg_write_out`  out  1  gated register write enable
- `mem_write_out`  out  1  gated memory write enable
- `input_value`  out  DATA_WIDTH  captured switch value (drives `memtoReg`=11 path)
- `display_value`  out  DATA_WIDTH  last output value
- `display_valid`  out  1  sticky, set by first output instruction
- `waiting_input`  out  1  LED, high in `WAIT_PRESS` or `WAIT_RELEASE`
- `halted`  out  1  high in `HALTED`

## Operation
Button path:
- `enter_btn` passes through a 2-FF synchronizer, giving `btn_s`.
- A debounce counter increments while `btn_s` equals the level the current state is waiting for. It clears on any mismatch and on every state change.

States: `RUN`, `WAIT_PRESS`, `WAIT_RELEASE`, `COMMIT`, `HALTED`.

- **RUN**
  - Priority: `halt` > `input_flag` > `output_flag`.
  - `halt` → `HALTED`.
  - `input_flag` → `WAIT_PRESS`.
  - `output_flag`: `display_value` ← `out_data` and `display_valid` ← 1 at the edge; stay in `RUN`, no stall.
- **WAIT_PRESS**
  - Count while `btn_s` = 1.
  - When the count reaches `DEBOUNCE_CYCLES`: `input_value` ← `switch_data` at that edge, → `WAIT_RELEASE`.
  - A button already held on entry counts.
- **WAIT_RELEASE**
  - Count while `btn_s` = 0.
  - When the count reaches `DEBOUNCE_CYCLES` → `COMMIT`.
- **COMMIT**
  - Single cycle; the input instruction retires. → `RUN`.
  - The decoder still presents `input_flag` during this cycle; it is ignored.
- **HALTED**
  - Absorbing; exits only via `rst`.

Combinational outputs:
- `pc_enable` = 1 in `COMMIT`, and in `RUN` when neither `halt` nor `input_flag` is asserted; 0 otherwise, and 0 while `rst` is high.
- `reg_write_out` = `reg_write_in & pc_enable`.
- `mem_write_out` = `mem_write_in & pc_enable`.
- `waiting_input` and `halted` are decoded from state.

Reset: state `RUN`; synchronizer, counter, `input_value`, `display_value` and `display_valid` all 0. All outputs read 0 while `rst` is high.

## Timing
- Output instruction: zero stall. `display_value` is valid the cycle after the instruction.
- Input instruction: `pc_enable` drops combinationally in the same cycle `input_flag` appears.
  - Minimum stall = 2 (sync) + `DEBOUNCE_CYCLES` (press) + `DEBOUNCE_CYCLES` (release) + 1 (`COMMIT`) cycles after the button is pressed.
  - `input_value` is stable from capture through `COMMIT`.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles are ignored in both directions.
- HALT: `pc_enable` = 0 in the HALT cycle and every cycle after it. No writes retire.
- `rst` asserted mid-stall returns to `RUN` asynchronously. No partial input commit.
- Writes are never issued twice for one instruction. Stalled cycles gate them to 0.

## Test plan
- **Reset:** assert `rst` with `enter_btn`=1 and all flags set → all outputs 0; after release, `RUN` with `pc_enable`=1 and `display_valid`=0.
- **Output:** `output_flag`=1, `out_data`=0x0000_00A5 for one cycle → `display_value`=0xA5 and `display_valid`=1 the next cycle, `pc_enable` never drops.
- **Input, clean press** (`DEBOUNCE_CYCLES`=4): `input_flag`=1, `reg_write_in`=1, `switch_data`=0x1234; press button for 10 cycles, then release.
  - `pc_enable`=0 and `reg_write_out`=0 throughout the stall.
  - `input_value`=0x1234.
  - Exactly one `COMMIT` cycle with `pc_enable`=1 and `reg_write_out`=1.
- **Bounce:** during `WAIT_PRESS` pulse the button for 3 cycles, twice → stays in `WAIT_PRESS`, `input_value` unchanged. A subsequent 4-cycle pulse advances to `WAIT_RELEASE`.
- **HALT:** `halt`=1 with `mem_write_in`=1 → `pc_enable`=0 and `mem_write_out`=0 immediately; `halted`=1 permanently despite later flags and button activity; `rst` clears it.
- **Reset mid-input:** assert `rst` in `WAIT_RELEASE` → `RUN` on the next cycle, `input_value`=0, no `reg_write_out` pulse.

Source files
------------

// File: rtl/io_stall_controller.sv
// io_stall_controller
// Sequences the decoder's halt / input / output strobes into multi-cycle
// behaviour: stalls the PC on an input instruction until a debounced button
// press and release, latches output values for the display, and freezes the
// core permanently on HALT. Register and memory writes are gated so nothing
// architectural is written while the PC is stalled.
//
// Ports:
//   clk, rst        system clock (rising edge), async active-high reset
//   halt            decoder HALT strobe
//   input_flag      decoder input-instruction strobe
//   output_flag     decoder output-instruction strobe
//   reg_write_in    decoder register write enable
//   mem_write_in    decoder memory write enable
//   enter_btn       raw asynchronous confirm button
//   switch_data     board switches
//   out_data        register-file value for an output instruction
//   pc_enable       PC / instruction retire enable (combinational)
//   reg_write_out   gated register write enable (combinational)
//   mem_write_out   gated memory write enable (combinational)
//   input_value     captured switch value
//   display_value   last output value
//   display_valid   sticky, set by the first output instruction
//   waiting_input   high while waiting for button press or release
//   halted          high once HALT has executed
module io_stall_controller #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  input  logic                  input_flag,
  input  logic                  output_flag,
  input  logic                  reg_write_in,
  input  logic                  mem_write_in,
  input  logic                  enter_btn,
  input  logic [DATA_WIDTH-1:0] switch_data,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic                  pc_enable,
  output logic                  reg_write_out,
  output logic                  mem_write_out,
  output logic [DATA_WIDTH-1:0] input_value,
  output logic [DATA_WIDTH-1:0] display_value,
  output logic                  display_valid,
  output logic                  waiting_input,
  output logic                  halted
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    RUN          = 3'd0,
    WAIT_PRESS   = 3'd1,
    WAIT_RELEASE = 3'd2,
    COMMIT       = 3'd3,
    HALTED       = 3'd4
  } state_t;

  state_t           state;
  logic             btn_meta;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= enter_btn;
      btn_s    <= btn_meta;
    end
  end

  // Sequencer: the debounce counter clears on every state change, so each
  // wait state starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      cnt           <= '0;
      input_value   <= '0;
      display_value <= '0;
      display_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cnt <= '0;
          if (halt) begin
            state <= HALTED;
          end else if (input_flag) begin
            state <= WAIT_PRESS;
          end else if (output_flag) begin
            display_value <= out_data;
            display_valid <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          if (btn_s) begin
            if (cnt == CNT_LAST) begin
              input_value <= switch_data;
              state       <= WAIT_RELEASE;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (!btn_s) begin
            if (cnt == CNT_LAST) begin
              state <= COMMIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        COMMIT: begin
          // input_flag is still presented here and deliberately ignored
          state <= RUN;
          cnt   <= '0;
        end
        HALTED: begin
          cnt <= '0;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Retire only in COMMIT, or in RUN for instructions that do not stall
  assign pc_enable = !rst &&
                     ((state == COMMIT) ||
                      ((state == RUN) && !halt && !input_flag));

  assign reg_write_out = reg_write_in & pc_enable;
  assign mem_write_out = mem_write_in & pc_enable;
  assign waiting_input = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
  assign halted        = (state == HALTED);

endmodule

// File: tb/tb_io_stall_controller.sv
// Directed self-checking bench for io_stall_controller (DEBOUNCE_CYCLES = 4).
module tb_io_stall_controller;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          halt;
  logic          input_flag;
  logic          output_flag;
  logic          reg_write_in;
  logic          mem_write_in;
  logic          enter_btn;
  logic [DW-1:0] switch_data;
  logic [DW-1:0] out_data;
  logic          pc_enable;
  logic          reg_write_out;
  logic          mem_write_out;
  logic [DW-1:0] input_value;
  logic [DW-1:0] display_value;
  logic          display_valid;
  logic          waiting_input;
  logic          halted;

  int errors;
  int checks;

  io_stall_controller #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .halt          (halt),
    .input_flag    (input_flag),
    .output_flag   (output_flag),
    .reg_write_in  (reg_write_in),
    .mem_write_in  (mem_write_in),
    .enter_btn     (enter_btn),
    .switch_data   (switch_data),
    .out_data      (out_data),
    .pc_enable     (pc_enable),
    .reg_write_out (reg_write_out),
    .mem_write_out (mem_write_out),
    .input_value   (input_value),
    .display_value (display_value),
    .display_valid (display_valid),
    .waiting_input (waiting_input),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int  cyc;
    int  commit_cyc;
    int  bad_writes;
    bit  done;

    errors = 0;
    checks = 0;

    // Reset with everything asserted: all outputs must read 0
    rst          = 1'b1;
    halt         = 1'b1;
    input_flag   = 1'b1;
    output_flag  = 1'b1;
    reg_write_in = 1'b1;
    mem_write_in = 1'b1;
    enter_btn    = 1'b1;
    switch_data  = 32'hFFFF_FFFF;
    out_data     = 32'hFFFF_FFFF;
    steps(2);
    #1;
    chk("rst_pc",   32'(pc_enable), 32'd0);
    chk("rst_rw",   32'(reg_write_out), 32'd0);
    chk("rst_mw",   32'(mem_write_out), 32'd0);
    chk("rst_inv",  input_value, 32'd0);
    chk("rst_disp", display_value, 32'd0);
    chk("rst_dv",   32'(display_valid), 32'd0);
    chk("rst_wait", 32'(waiting_input), 32'd0);
    chk("rst_halt", 32'(halted), 32'd0);

    halt         = 1'b0;
    input_flag   = 1'b0;
    output_flag  = 1'b0;
    reg_write_in = 1'b0;
    mem_write_in = 1'b0;
    enter_btn    = 1'b0;
    step();
    rst = 1'b0;
    steps(3);
    #1;
    chk("post_rst_pc", 32'(pc_enable), 32'd1);
    chk("post_rst_dv", 32'(display_valid), 32'd0);

    // Output instruction: no stall, display updated next cycle
    output_flag  = 1'b1;
    out_data     = 32'h0000_00A5;
    reg_write_in = 1'b1;
    #1;
    chk("out_pc", 32'(pc_enable), 32'd1);
    chk("out_rw", 32'(reg_write_out), 32'd1);
    step();
    output_flag = 1'b0;
    out_data    = 32'h0;
    #1;
    chk("out_disp", display_value, 32'h0000_00A5);
    chk("out_dv",   32'(display_valid), 32'd1);
    chk("out_pc2",  32'(pc_enable), 32'd1);

    // Input instruction, clean 10-cycle press starting one cycle after the
    // strobe: capture at edge 7, release seen at edge 13, COMMIT in cycle 17
    cyc        = 0;
    commit_cyc = -1;
    bad_writes = 0;
    done       = 1'b0;
    while (!done && cyc < 40) begin
      input_flag  = 1'b1;
      enter_btn   = (cyc >= 1 && cyc <= 10);
      switch_data = (cyc <= 6) ? 32'h0000_1234 : 32'h0000_BEEF;
      #1;
      if (cyc == 5) chk("in_wait", 32'(waiting_input), 32'd1);
      if (pc_enable) begin
        commit_cyc = cyc;
        done       = 1'b1;
        chk("commit_rw",  32'(reg_write_out), 32'd1);
        chk("commit_val", input_value, 32'h0000_1234);
        chk("commit_led", 32'(waiting_input), 32'd0);
      end else if (reg_write_out) begin
        bad_writes = bad_writes + 1;
      end
      step();
      cyc = cyc + 1;
    end
    chk("commit_cycle", 32'(commit_cyc), 32'd17);
    chk("stall_writes", 32'(bad_writes), 32'd0);
    input_flag = 1'b0;
    #1;
    chk("after_commit_pc",  32'(pc_enable), 32'd1);
    chk("after_commit_val", input_value, 32'h0000_1234);

    // Bounce: two 3-cycle pulses must not advance out of WAIT_PRESS
    input_flag  = 1'b1;
    switch_data = 32'h0000_5678;
    step();
    #1;
    chk("bnc_wait", 32'(waiting_input), 32'd1);
    chk("bnc_pc",   32'(pc_enable), 32'd0);
    for (int p = 0; p < 2; p++) begin
      enter_btn = 1'b1;
      steps(3);
      enter_btn = 1'b0;
      steps(4);
    end
    chk("bnc_hold_val",  input_value, 32'h0000_1234);
    chk("bnc_hold_wait", 32'(waiting_input), 32'd1);
    enter_btn = 1'b1;
    steps(4);
    enter_btn = 1'b0;
    steps(2);
    #1;
    chk("bnc_capture", input_value, 32'h0000_5678);
    chk("bnc_wait2",   32'(waiting_input), 32'd1);
    chk("bnc_pc2",     32'(pc_enable), 32'd0);

    // Reset mid-input while in WAIT_RELEASE
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_pc",   32'(pc_enable), 32'd0);
    chk("mid_rst_rw",   32'(reg_write_out), 32'd0);
    chk("mid_rst_val",  input_value, 32'd0);
    chk("mid_rst_wait", 32'(waiting_input), 32'd0);
    step();
    rst        = 1'b0;
    input_flag = 1'b0;
    #1;
    chk("mid_post_pc",   32'(pc_enable), 32'd1);
    chk("mid_post_wait", 32'(waiting_input), 32'd0);
    steps(3);
    chk("mid_post_val",  input_value, 32'd0);

    // HALT: immediate stall and write gating, absorbing until reset
    reg_write_in = 1'b0;
    mem_write_in = 1'b1;
    halt         = 1'b1;
    #1;
    chk("halt_pc", 32'(pc_enable), 32'd0);
    chk("halt_mw", 32'(mem_write_out), 32'd0);
    step();
    halt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      input_flag  = 1'b1;
      output_flag = 1'b1;
      out_data    = 32'h0000_0077;
      enter_btn   = (i >= 2 && i < 9);
      #1;
      chk("halt_hold", {29'd0, halted, pc_enable, mem_write_out}, 32'b100);
      step();
    end
    chk("halt_disp", display_value, 32'd0);
    chk("halt_dv",   32'(display_valid), 32'd0);
    chk("halt_wait", 32'(waiting_input), 32'd0);
    rst = 1'b1;
    #1;
    chk("halt_rst", 32'(halted), 32'd0);
    step();
    input_flag   = 1'b0;
    output_flag  = 1'b0;
    enter_btn    = 1'b0;
    mem_write_in = 1'b0;
    rst          = 1'b0;
    #1;
    chk("halt_clear_pc",   32'(pc_enable), 32'd1);
    chk("halt_clear_halt", 32'(halted), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
